// File: rtl/aes_pkg.sv
// Shared AES definitions: block sizes, field polynomial,
// iterative-engine states and GF(2^8) multiply.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } iter_state_e;

  // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      if (x[7]) x = {x[6:0], 1'b0} ^ AES_POLY;
      else      x = {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: inverse affine
// transform followed by GF(2^8) inversion.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  logic [7:0] w_aff;
  logic [7:0] w_inv;

  // b'_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ c_i, c = 0x05
  assign w_aff = {i_x[1:0], i_x[7:2]}
               ^ {i_x[4:0], i_x[7:5]}
               ^ {i_x[6:0], i_x[7]}
               ^ 8'h05;

  // Inverse as a^254 = a^2*a^4*...*a^128; zero stays zero
  always_comb begin
    logic [7:0] v_sq;
    logic [7:0] v_acc;
    v_sq  = w_aff;
    v_acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      v_sq  = gf_mul(v_sq, v_sq);
      v_acc = gf_mul(v_acc, v_sq);
    end
    w_inv = v_acc;
  end

  assign o_y = w_inv;

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES bytes of the 128-bit
// state per clock, valid/ready on both sides.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int N  = AES_BYTES / LANES;
  localparam int GW = 8 * LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1,2,4,8,16");
  end

  iter_state_e            r_state;
  iter_state_e            w_state;
  logic [AES_BLOCK_W-1:0] r_st;
  logic [AES_BLOCK_W-1:0] w_st;
  logic [CW-1:0]          r_cnt;
  logic [GW-1:0]          w_grp;
  logic [GW-1:0]          w_sub;
  logic                   w_last;

  assign w_last = (r_cnt == CW'(N - 1));

  // Pick the byte group addressed by the counter
  always_comb begin
    w_grp = '0;
    for (int g = 0; g < N; g++) begin
      if (r_cnt == CW'(g)) w_grp = r_st[g*GW +: GW];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .i_x (w_grp[8*l +: 8]),
      .o_y (w_sub[8*l +: 8])
    );
  end

  // Write the substituted group back into its slot
  always_comb begin
    w_st = r_st;
    for (int g = 0; g < N; g++) begin
      if (r_cnt == CW'(g)) w_st[g*GW +: GW] = w_sub;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state;
  end

  // Next-state decode
  always_comb begin
    w_state = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state = BUSY;
      BUSY: if (w_last)   w_state = DONE;
      DONE: if (out_ready) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // Working state and group counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_st  <= in_data;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_st  <= w_st;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign out_data  = r_st;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter across all legal LANES
// values, with a forward-S-box derived reference table.
module tb_inv_sub_bytes_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]   iv;
  logic [4:0]   orr;
  logic [127:0] id [5];
  wire  [4:0]   ir;
  wire  [4:0]   ov;
  wire  [4:0]   bz;
  wire  [127:0] od [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (id[g]),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .out_data  (od[g]),
      .busy      (bz[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
    end
    return p;
  endfunction

  // Forward S-box by brute-force inverse + affine,
  // then inverted into a lookup table.
  task automatic build_ref();
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      x = 8'(a);
      y = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(x, 8'(b)) == 8'h01) y = 8'(b);
      s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]}
            ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]}
            ^ 8'h63;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] ref_isb(
    input logic [127:0] d
  );
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  // Offer a block at a negedge; returns after accept edge
  task automatic put_block(
    input int g,
    input logic [127:0] d
  );
    int w;
    w = 0;
    id[g] = d;
    iv[g] = 1'b1;
    while (!ir[g] && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
  endtask

  // Cycles from accept edge to out_valid, plus busy cycles
  task automatic wait_out(
    input  int g,
    output int lat,
    output int bcnt
  );
    @(negedge clk);
    lat  = 0;
    bcnt = 0;
    while (!ov[g] && lat < 64) begin
      if (bz[g]) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take_out(input int g);
    orr[g] = 1'b1;
    @(posedge clk);
    #1;
    orr[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv    = '0;
    orr   = '0;
    for (int g = 0; g < 5; g++) id[g] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ir[2] !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", ir[2]);
    end
    checks++;
    if (ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", ov[2]);
    end
    checks++;
    if (bz[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bz[2]);
    end
    checks++;
    if (od[2] !== 128'h0) begin
      errors++;
      $display("FAIL reset_out_data got %h exp 0", od[2]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all63();
    int lat;
    int bc;
    put_block(2, {16{8'h63}});
    wait_out(2, lat, bc);
    checks++;
    if (od[2] !== 128'h0) begin
      errors++;
      $display("FAIL all63_data got %h exp 0", od[2]);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL all63_latency got %0d exp 4", lat);
    end
    take_out(2);
  endtask

  task automatic test_fips_vector();
    int lat;
    int bc;
    logic [127:0] exp_d;
    exp_d = 128'h0f0e0d0c0b0a09080706050403020100;
    put_block(2, 128'h76abd7fe2b670130c56f6bf27b777c63);
    wait_out(2, lat, bc);
    checks++;
    if (od[2] !== exp_d) begin
      errors++;
      $display("FAIL fips_data got %h exp %h", od[2], exp_d);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL fips_busy_cycles got %0d exp 4", bc);
    end
    take_out(2);
    checks++;
    if (ir[2] !== 1'b1) begin
      errors++;
      $display("FAIL fips_rearm got %b exp 1", ir[2]);
    end
  endtask

  task automatic test_spot_bytes();
    int lat;
    int bc;
    logic [127:0] exp_d;
    exp_d = 128'h0000000000000000000000007d48ff52;
    put_block(2, 128'h636363636363636363636363ff521600);
    wait_out(2, lat, bc);
    checks++;
    if (od[2] !== exp_d) begin
      errors++;
      $display("FAIL spot_data got %h exp %h", od[2], exp_d);
    end
    take_out(2);
  endtask

  task automatic test_exhaustive();
    int lat;
    int bc;
    int n;
    logic [127:0] blk;
    logic [127:0] exp_d;
    for (int g = 0; g < 5; g++) begin
      n = 16 >> g;
      for (int k = 0; k < 256; k++) begin
        for (int i = 0; i < 16; i++)
          blk[8*i +: 8] = 8'(k + i);
        exp_d = ref_isb(blk);
        put_block(g, blk);
        wait_out(g, lat, bc);
        checks++;
        if (od[g] !== exp_d) begin
          errors++;
          $display("FAIL exh_data lanes=%0d k=%0d got %h exp %h",
                   1 << g, k, od[g], exp_d);
        end
        checks++;
        if (lat !== n) begin
          errors++;
          $display("FAIL exh_latency lanes=%0d got %0d exp %0d",
                   1 << g, lat, n);
        end
        take_out(g);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bc;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] snap;
    a = 128'h0123456789abcdeffedcba9876543210;
    b = 128'h00112233445566778899aabbccddeeff;
    put_block(2, a);
    wait_out(2, lat, bc);
    snap = od[2];
    checks++;
    if (snap !== ref_isb(a)) begin
      errors++;
      $display("FAIL bp_first got %h exp %h", snap, ref_isb(a));
    end
    id[2] = b;
    iv[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ov[2] !== 1'b1 || od[2] !== snap || ir[2] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b r=%b d=%h exp v=1 r=0 d=%h",
                 c, ov[2], ir[2], od[2], snap);
      end
    end
    orr[2] = 1'b1;
    @(posedge clk);
    #1;
    orr[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (ir[2] !== 1'b1 || ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got r=%b v=%b exp r=1 v=0",
               ir[2], ov[2]);
    end
    @(posedge clk);
    #1;
    iv[2] = 1'b0;
    wait_out(2, lat, bc);
    checks++;
    if (od[2] !== ref_isb(b) || lat !== 4) begin
      errors++;
      $display("FAIL bp_second got %h lat %0d exp %h lat 4",
               od[2], lat, ref_isb(b));
    end
    take_out(2);
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    put_block(2, 128'hdeadbeefcafef00d0badc0de12345678);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (od[2] !== 128'h0 || ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_out got v=%b d=%h exp v=0 d=0",
               ov[2], od[2]);
    end
    checks++;
    if (ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags got r=%b b=%b exp r=1 b=0",
               ir[2], bz[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put_block(2, {16{8'h63}});
    wait_out(2, lat, bc);
    checks++;
    if (od[2] !== 128'h0 || lat !== 4) begin
      errors++;
      $display("FAIL rstmid_after got %h lat %0d exp 0 lat 4",
               od[2], lat);
    end
    take_out(2);
  endtask

  task automatic test_back_to_back();
    int t;
    int prev;
    int w;
    int lat;
    logic [127:0] blk;
    prev = 0;
    orr[2] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      id[2] = blk;
      iv[2] = 1'b1;
      w = 0;
      while (!ir[2] && w < 50) begin
        @(negedge clk);
        w++;
      end
      @(posedge clk);
      #1;
      t = cyc;
      if (b > 0) begin
        checks++;
        if (t - prev !== 6) begin
          errors++;
          $display("FAIL b2b_spacing blk=%0d got %0d exp 6",
                   b, t - prev);
        end
      end
      prev = t;
      @(negedge clk);
      lat = 0;
      while (!ov[2] && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (od[2] !== ref_isb(blk)) begin
        errors++;
        $display("FAIL b2b_data blk=%0d got %h exp %h",
                 b, od[2], ref_isb(blk));
      end
    end
    iv[2] = 1'b0;
    @(posedge clk);
    #1;
    orr[2] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    build_ref();
    test_reset();
    test_all63();
    test_fips_vector();
    test_spot_bytes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
